// File: rtl/sram_arbiter_pkg.sv
// Shared constants and encodings for the SRAM arbiter and its half-word sequencer.
package sram_arbiter_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT      = 32;
  localparam int unsigned SRAM_DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned SRAM_ADDR_WIDTH_DEFAULT = 18;
  localparam int unsigned WAIT_CYCLES_DEFAULT     = 1;

  // Transaction state: one word is an LO half-word phase followed by an HI phase.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } owner_e;

  // Phase counter width; at least one bit even when WAIT_CYCLES is zero.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/sram_halfword_seq.sv
// Half-word phase sequencer: times each LO/HI phase, drives the SRAM pins and
// captures read data. The owning FSM state is supplied by sram_arbiter.
module sram_halfword_seq
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEFAULT,
  parameter int unsigned SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEFAULT,
  parameter int unsigned WAIT_CYCLES     = WAIT_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  state_e                       state,
  input  logic                         op_write,
  input  logic [SRAM_ADDR_WIDTH-2:0]   word_addr,
  input  logic [2*SRAM_DATA_WIDTH-1:0] wdata,
  output logic                         phase_done,
  output logic [2*SRAM_DATA_WIDTH-1:0] rdata_word,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_dq_out,
  output logic                         sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_dq_in,
  output logic                         sram_we_n,
  output logic                         sram_oe_n
);

  localparam int unsigned CntWidth = cnt_width(WAIT_CYCLES);

  logic [CntWidth-1:0]        cnt_q, cnt_d;
  logic [SRAM_DATA_WIDTH-1:0] lo_q, lo_d;
  logic                       in_phase;
  logic                       is_hi;

  assign in_phase   = (state == StLo) || (state == StHi);
  assign is_hi      = (state == StHi);
  assign phase_done = in_phase && (cnt_q == CntWidth'(WAIT_CYCLES));

  // HI half is taken straight from the bus so the full word is ready on the last HI cycle.
  assign rdata_word = {sram_dq_in, lo_q};

  // Phase counter and LO capture next-state; counter restarts at every phase entry.
  always_comb begin
    cnt_d = '0;
    lo_d  = lo_q;
    if (in_phase && !phase_done) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
    if ((state == StLo) && phase_done && !op_write) begin
      lo_d = sram_dq_in;
    end
  end

  // Counter and LO half-word registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
    end
  end

  // SRAM pin drive; idle values outside LO/HI.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (in_phase) begin
      sram_addr = {word_addr, is_hi};
      if (op_write) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = is_hi ? wdata[2*SRAM_DATA_WIDTH-1:SRAM_DATA_WIDTH]
                            : wdata[SRAM_DATA_WIDTH-1:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit SRAM between instruction fetch and MEM-stage data accesses.
// MEM has fixed priority; each word is moved as two half-word phases.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = WORD_WIDTH_DEFAULT,
  parameter int unsigned SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEFAULT,
  parameter int unsigned SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEFAULT,
  parameter int unsigned WAIT_CYCLES     = WAIT_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_req,
  input  logic [WORD_WIDTH-1:0]      if_addr,
  output logic [WORD_WIDTH-1:0]      if_rdata,
  output logic                       if_ready,
  output logic                       if_stall,
  input  logic                       mem_rd_en,
  input  logic                       mem_wr_en,
  input  logic [WORD_WIDTH-1:0]      mem_addr,
  input  logic [WORD_WIDTH-1:0]      mem_wdata,
  output logic [WORD_WIDTH-1:0]      mem_rdata,
  output logic                       mem_ready,
  output logic                       mem_stall,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  state_e                      state_q, state_d;
  owner_e                      owner_q, owner_d;
  logic                        write_q, write_d;
  logic [SRAM_ADDR_WIDTH-2:0]  word_addr_q, word_addr_d;
  logic [WORD_WIDTH-1:0]       wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]       if_rdata_q, if_rdata_d;
  logic [WORD_WIDTH-1:0]       mem_rdata_q, mem_rdata_d;
  logic                        mem_req;
  logic                        phase_done;
  logic [WORD_WIDTH-1:0]       rdata_word;

  // Byte offset and bits above the SRAM range are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], if_addr[1:0],
                              mem_addr[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], mem_addr[1:0]};

  assign mem_req = mem_rd_en | mem_wr_en;

  // Arbitration FSM next-state, grant latching and read-data update.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          owner_d     = OwnMem;
          write_d     = mem_wr_en;  // rd+wr together is illegal; write wins
          word_addr_d = mem_addr[SRAM_ADDR_WIDTH:2];
          wdata_d     = mem_wdata;
          state_d     = StLo;
        end else if (if_req) begin
          owner_d     = OwnIf;
          write_d     = 1'b0;
          word_addr_d = if_addr[SRAM_ADDR_WIDTH:2];
          wdata_d     = '0;
          state_d     = StLo;
        end
      end
      StLo: begin
        if (phase_done) begin
          state_d = StHi;
        end
      end
      StHi: begin
        if (phase_done) begin
          state_d = StDone;
          if (!write_q) begin
            if (owner_q == OwnIf) begin
              if_rdata_d = rdata_word;
            end else begin
              mem_rdata_d = rdata_word;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Arbiter state and per-owner read data registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      write_q     <= 1'b0;
      word_addr_q <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Ready pulses and stalls are combinational so the pipeline sees them in the same cycle.
  always_comb begin
    if_ready  = (state_q == StDone) && (owner_q == OwnIf);
    mem_ready = (state_q == StDone) && (owner_q == OwnMem);
    if_stall  = if_req & ~if_ready;
    mem_stall = mem_req & ~mem_ready;
    if_rdata  = if_rdata_q;
    mem_rdata = mem_rdata_q;
  end

  sram_halfword_seq #(
    .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH),
    .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH),
    .WAIT_CYCLES     (WAIT_CYCLES)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .state       (state_q),
    .op_write    (write_q),
    .word_addr   (word_addr_q),
    .wdata       (wdata_q),
    .phase_done  (phase_done),
    .rdata_word  (rdata_word),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .if_stall    (if_stall),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_stall   (mem_stall),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  // SRAM model: a write lands only after a full two-cycle strobe at one address,
  // committed when the address moves or we_n rises (minimum write pulse width).
  logic [15:0] sram_mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [17:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  int          wr_cnt = 0;

  assign sram_dq_in = !sram_oe_n ? sram_mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pl_en) begin
      sram_mem[pl_addr] <= pl_data;
    end else if (!sram_we_n && sram_dq_oe) begin
      if (wr_cnt != 0 && sram_addr == wr_addr) begin
        wr_cnt <= wr_cnt + 1;
      end else begin
        if (wr_cnt >= 2) sram_mem[wr_addr[7:0]] <= wr_data;
        wr_cnt <= 1;
      end
      wr_addr <= sram_addr;
      wr_data <= sram_dq_out;
    end else begin
      if (wr_cnt >= 2) sram_mem[wr_addr[7:0]] <= wr_data;
      wr_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " if_rdata"}, if_rdata, 32'h0);
    check({tag, " mem_rdata"}, mem_rdata, 32'h0);
    check({tag, " if_ready"}, {31'b0, if_ready}, 32'h0);
    check({tag, " mem_ready"}, {31'b0, mem_ready}, 32'h0);
    check({tag, " sram_addr"}, {14'b0, sram_addr}, 32'h0);
    check({tag, " dq_out"}, {16'b0, sram_dq_out}, 32'h0);
    check({tag, " dq_oe"}, {31'b0, sram_dq_oe}, 32'h0);
    check({tag, " we_n"}, {31'b0, sram_we_n}, 32'h1);
    check({tag, " oe_n"}, {31'b0, sram_oe_n}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_word [0:2];
    exp_word[0] = 32'h1111_2222;
    exp_word[1] = 32'h3333_4444;
    exp_word[2] = 32'h5555_6666;

    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    preload(8'h08, 16'h5678); preload(8'h09, 16'h1234);
    preload(8'h00, 16'h2222); preload(8'h01, 16'h1111);
    preload(8'h02, 16'h4444); preload(8'h03, 16'h3333);
    preload(8'h04, 16'h6666); preload(8'h05, 16'h5555);

    // 1: reset mid-idle for two edges
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check_reset_vals("t1");
    check("t1 if_stall", {31'b0, if_stall}, 32'h0);
    rst = 1'b1;

    // 2: IF read of 0x10
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10; #1;
    check("t2 c0 if_stall", {31'b0, if_stall}, 32'h1);
    check("t2 c0 sram_addr", {14'b0, sram_addr}, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t2 c%0d if_ready", c), {31'b0, if_ready}, (c == 5) ? 32'h1 : 32'h0);
      check($sformatf("t2 c%0d if_stall", c), {31'b0, if_stall}, (c == 5) ? 32'h0 : 32'h1);
      check($sformatf("t2 c%0d sram_addr", c), {14'b0, sram_addr},
            (c <= 2) ? 32'h8 : (c <= 4) ? 32'h9 : 32'h0);
      check($sformatf("t2 c%0d oe_n", c), {31'b0, sram_oe_n}, (c <= 4) ? 32'h0 : 32'h1);
    end
    check("t2 if_rdata", if_rdata, 32'h1234_5678);
    if_req = 1'b0;
    @(negedge clk);
    check("t2 c6 if_ready", {31'b0, if_ready}, 32'h0);
    check("t2 c6 if_rdata hold", if_rdata, 32'h1234_5678);

    // 3: MEM write of 0xDEADBEEF to 0x40, then read back
    @(negedge clk); mem_wr_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF; #1;
    check("t3 c0 mem_stall", {31'b0, mem_stall}, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t3 c%0d sram_addr", c), {14'b0, sram_addr},
            (c <= 2) ? 32'h20 : (c <= 4) ? 32'h21 : 32'h0);
      check($sformatf("t3 c%0d dq_out", c), {16'b0, sram_dq_out},
            (c <= 2) ? 32'hBEEF : (c <= 4) ? 32'hDEAD : 32'h0);
      check($sformatf("t3 c%0d we_n", c), {31'b0, sram_we_n}, (c <= 4) ? 32'h0 : 32'h1);
      check($sformatf("t3 c%0d dq_oe", c), {31'b0, sram_dq_oe}, (c <= 4) ? 32'h1 : 32'h0);
      check($sformatf("t3 c%0d mem_ready", c), {31'b0, mem_ready}, (c == 5) ? 32'h1 : 32'h0);
    end
    mem_wr_en = 1'b0; mem_rd_en = 1'b1;
    for (int c = 6; c <= 11; c++) begin
      @(negedge clk);
      check($sformatf("t3 c%0d rd mem_ready", c), {31'b0, mem_ready},
            (c == 11) ? 32'h1 : 32'h0);
    end
    check("t3 mem_rdata", mem_rdata, 32'hDEAD_BEEF);
    mem_rd_en = 1'b0;

    // 4: simultaneous IF and MEM requests; MEM first
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; mem_rd_en = 1'b1; mem_addr = 32'h8; #1;
    check("t4 c0 if_stall", {31'b0, if_stall}, 32'h1);
    check("t4 c0 mem_stall", {31'b0, mem_stall}, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) check("t4 c1 sram_addr", {14'b0, sram_addr}, 32'h4);
      check($sformatf("t4 c%0d mem_ready", c), {31'b0, mem_ready}, (c == 5) ? 32'h1 : 32'h0);
      check($sformatf("t4 c%0d if_ready", c), {31'b0, if_ready}, 32'h0);
    end
    check("t4 mem_rdata", mem_rdata, 32'h5555_6666);
    mem_rd_en = 1'b0;
    for (int c = 6; c <= 11; c++) begin
      @(negedge clk);
      if (c == 7) check("t4 c7 sram_addr", {14'b0, sram_addr}, 32'h8);
      check($sformatf("t4 c%0d if_ready", c), {31'b0, if_ready}, (c == 11) ? 32'h1 : 32'h0);
      check($sformatf("t4 c%0d mem_ready", c), {31'b0, mem_ready}, 32'h0);
    end
    check("t4 if_rdata", if_rdata, 32'h1234_5678);
    if_req = 1'b0;

    // 5: reset during the HI phase of a write
    preload(8'h20, 16'h0000); preload(8'h21, 16'h0000);
    @(negedge clk); mem_wr_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("t5 c3 sram_addr", {14'b0, sram_addr}, 32'h21);
    check("t5 c3 we_n", {31'b0, sram_we_n}, 32'h0);
    rst = 1'b0; mem_wr_en = 1'b0;
    @(negedge clk);
    check_reset_vals("t5");
    rst = 1'b1;
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("t5 c%0d mem_ready", c), {31'b0, mem_ready}, 32'h0);
    end
    check("t5 sram[0x20]", {16'b0, sram_mem[8'h20]}, 32'hBEEF);
    check("t5 sram[0x21]", {16'b0, sram_mem[8'h21]}, 32'h0000);

    // 6: back-to-back IF reads with request held high
    @(negedge clk); if_req = 1'b1; if_addr = 32'h0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check($sformatf("t6 c%0d if_ready", c), {31'b0, if_ready},
            (c == 5 || c == 11 || c == 17) ? 32'h1 : 32'h0);
      if (c == 5 || c == 11 || c == 17) begin
        check($sformatf("t6 c%0d if_rdata", c), if_rdata, exp_word[(c - 5) / 6]);
        if_addr = if_addr + 32'h4;
      end
    end
    if_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
